// File: rtl/qnr_div_pkg.sv
// Shared types and helpers for the pipelined restoring divider (qnr_pipe_divider).
// Widths here set the stage record layout; the top's parameters default to them.
package qnr_div_pkg;

    localparam int QNR_DW = 16;
    localparam int QNR_VW = 8;
    localparam int QNR_TW = 4;

    typedef struct packed {
        logic              valid;
        logic [QNR_VW:0]   prem;
        logic [QNR_DW-1:0] pquot;
        logic [QNR_DW-1:0] dend;
        logic [QNR_VW-1:0] dsor;
        logic [QNR_TW-1:0] tag;
        logic              dbz;
    } stage_t;

    typedef struct packed {
        logic            qbit;
        logic [QNR_VW:0] prem;
    } trial_t;

    localparam logic [QNR_DW-1:0] DBZ_QUOTIENT = '1;

    // Shift in the next dividend bit, then keep the difference only if it did not go negative.
    function automatic trial_t trial_subtract(input logic [QNR_VW:0]   prem,
                                              input logic              next_bit,
                                              input logic [QNR_VW-1:0] dsor);
        trial_t            res;
        logic [QNR_VW+1:0] shifted;
        shifted  = {prem, next_bit};
        res.qbit = (shifted >= {2'b00, dsor});
        if (res.qbit)
            res.prem = shifted[QNR_VW:0] - {1'b0, dsor};
        else
            res.prem = shifted[QNR_VW:0];
        return res;
    endfunction

endpackage

// File: rtl/qnr_div_stage.sv
// One restoring-division step (decides quotient bit DW-1-K) followed by its
// stall-able stage register. Only the valid bit is cleared by reset.
module qnr_div_stage
    import qnr_div_pkg::*;
#(
    parameter int K = 0
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  stage_t prev,
    output stage_t curr
);

    trial_t t;
    stage_t step;

    always_comb begin
        t                      = trial_subtract(prev.prem, prev.dend[QNR_DW-1-K], prev.dsor);
        step                   = prev;
        step.prem              = t.prem;
        step.pquot[QNR_DW-1-K] = t.qbit;
    end

    always_ff @(posedge clk) begin
        if (rst)
            curr.valid <= 1'b0;
        else if (en)
            curr <= step;
    end

endmodule

// File: rtl/qnr_pipe_divider.sv
// Fully pipelined unsigned restoring divider, one quotient bit per stage, DW-cycle latency.
// Define QNR_ROUND_EN to round the quotient to nearest (saturating) in the final stage.
module qnr_pipe_divider
    import qnr_div_pkg::*;
#(
    parameter int DW = QNR_DW,
    parameter int VW = QNR_VW,
    parameter int TW = QNR_TW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          in_valid,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic [TW-1:0] out_tag,
    output logic          div_by_zero
);

    stage_t head;
    stage_t pipe [DW];
    stage_t last;
    logic   unused_bits;

    always_comb begin
        head       = '0;
        head.valid = in_valid;
        head.dend  = dividend;
        head.dsor  = divisor;
        head.tag   = in_tag;
        head.dbz   = (divisor == '0);
    end

    for (genvar k = 0; k < DW; k++) begin : g_stage
        if (k == 0) begin : g_first
            qnr_div_stage #(.K(k)) u_stage (
                .clk  (clk),
                .rst  (rst),
                .en   (en),
                .prev (head),
                .curr (pipe[k])
            );
        end else begin : g_rest
            qnr_div_stage #(.K(k)) u_stage (
                .clk  (clk),
                .rst  (rst),
                .en   (en),
                .prev (pipe[k-1]),
                .curr (pipe[k])
            );
        end
    end

    assign last        = pipe[DW-1];
    assign unused_bits = ^{last.prem[VW], last.dend, last.dsor};

    // Outputs are gated by valid so reset and bubbles present zeros, never stale data.
    always_comb begin
        out_valid   = last.valid;
        quotient    = '0;
        remainder   = '0;
        out_tag     = '0;
        div_by_zero = 1'b0;
        if (last.valid) begin
            out_tag     = last.tag;
            div_by_zero = last.dbz;
            if (last.dbz) begin
                quotient = DBZ_QUOTIENT;
            end else begin
                quotient  = last.pquot;
                remainder = last.prem[VW-1:0];
`ifdef QNR_ROUND_EN
                if (({last.prem[VW-1:0], 1'b0} >= {1'b0, last.dsor}) &&
                    (last.pquot != DBZ_QUOTIENT))
                    quotient = last.pquot + DW'(1);
`endif
            end
        end
    end

endmodule

// File: doc/qnr_pipe_divider.md
Name: qnr_pipe_divider

Overview:
- Parametrised, fully pipelined restoring divider for the quantiser (qnr) path of jpeg_encoder.
- Generalises the fixed per-bit quotient pipeline (q_pipe) to configurable dividend, divisor and tag widths.
- Adds valid/tag tracking, a global stall enable, divide-by-zero detection, and optional round-to-nearest.
- One quotient bit per stage; accepts one division per cycle.

Parameters:
DW, 16, dividend and quotient width; also the pipeline depth in stages
VW, 8, divisor and remainder width (VW <= DW)
TW, 4, width of the sideband tag carried alongside each operation

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
en  input  1  pipeline advance enable; 0 freezes every stage
in_valid  input  1  dividend/divisor/in_tag are valid this cycle
dividend  input  DW  unsigned dividend
divisor  input  VW  unsigned divisor
in_tag  input  TW  sideband tag, returned unchanged with the result
out_valid  output  1  result valid
quotient  output  DW  unsigned quotient
remainder  output  VW  unsigned remainder
out_tag  output  TW  tag of the result
div_by_zero  output  1  divisor was 0 for this result

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high, on rst.
- Reset: on any clk edge with rst=1, all stage valid bits, out_valid, quotient, remainder, out_tag and div_by_zero go to 0. rst overrides en. In-flight operations are discarded, with no partial outputs.
- Pipeline structure: DW registered stages.
  - Stage k (k=0..DW-1) decides quotient bit DW-1-k.
  - Shift the partial remainder (VW+1 bits) left, bringing in the next dividend bit.
  - Trial-subtract the divisor. If the result is non-negative, keep it and set the quotient bit; otherwise restore.
- Each stage register holds: valid, partial remainder, partial quotient, remaining dividend bits, divisor, tag, dbz.
- Latency: an operation accepted at edge N (in_valid=1, en=1) appears on outputs after edge N+DW-1 when en stays 1. That is DW cycles with no input register.
- Throughput: one operation per cycle. No backpressure output; the producer gates in_valid with en.
- en=0: no stage register updates. Outputs hold their values, including out_valid. in_valid is ignored in that cycle; the upstream must hold data.
- Divide by zero (divisor==0): dbz is flagged at stage 0 and travels with the operation. The output forces quotient = all ones, remainder = 0, div_by_zero = 1. out_valid behaves normally.
- Bubbles: stages with valid=0 still shift. Data fields may be don't-care, but out_valid=0 must hold and outputs must not produce X when valid.
- Simultaneous rst=1 and in_valid=1: reset wins and the input is dropped.
- Arithmetic: all unsigned. For dbz=0, quotient*divisor + remainder == dividend and remainder < divisor must hold exactly.

Optional Feature:
- Macro: QNR_ROUND_EN.
- Defined: round-to-nearest, applied combinationally in the final stage.
  - quotient = q + 1 when 2*r >= divisor; saturates at all ones.
  - remainder output is the unrounded r.
  - Latency unchanged. dbz results are unaffected.
- Undefined: truncating quotient. No rounding logic is present.

Decomposition:
- Package qnr_div_pkg holds:
  - the stage_t struct typedef (valid, prem, pquot, dend, dsor, tag, dbz), parametrised through localparam widths;
  - DBZ_QUOTIENT fill constant;
  - helper function for the trial subtract.
- Sub-module qnr_div_stage: one restoring step plus its stage register with enable. It is instantiated DW times in a generate loop. The top handles input packing, dbz detection, the output mux and optional rounding.

Test Plan:
- Basic: 1000/7, tag 3, en=1 -> 16 cycles later: quotient=142, remainder=6, out_tag=3, div_by_zero=0. With QNR_ROUND_EN: quotient=143.
- Back-to-back: 16 consecutive ops (i*1000+5)/(i+1), i=0..15 -> 16 consecutive out_valid cycles with exact results and tags in order. Check 0xFFFF/1 -> 0xFFFF r0 and 0xFFFF/0xFF -> 257 r0.
- Divide by zero: 1234/0 -> quotient=0xFFFF, remainder=0, div_by_zero=1. A following 10/3 -> 3 r1, div_by_zero=0.
- Stall: issue 3 ops, drop en for 3 cycles mid-flight -> outputs and out_valid frozen. Results emerge exactly 3 cycles later than the no-stall run, with identical values.
- Reset mid-operation: 8 ops in flight, pulse rst one cycle -> next cycle out_valid=0 and stays 0 until new ops complete. No stale results appear.
- Rounding saturation (QNR_ROUND_EN): 0xFFFF/2 -> 0x8000. Random 10k ops vs reference model -> all match.
